// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch unit for a multi-cycle RISC-V core.
// Requests a word at pc, latches it for the control unit, then waits for
// pc_load to advance (sequential or branch). Misaligned branch targets and
// instructions that never retire (hang) park the unit in a sticky fault.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   pc_load              current instruction retired, advance pc
//   pc_reset             synchronous restart at RESET_PC (exits fault)
//   branch_taken/target  redirect applied together with pc_load
//   imem_req/addr        instruction memory read request and address (= pc)
//   imem_ready/rdata     memory response, sampled only while requesting
//   pc, instr, opcode    current pc, latched instruction, instr[6:0]
//   instr_valid          instr/opcode hold a fetched instruction
//   fault                sticky misaligned-target / hang indication
//   instr_count          accepted fetches, wraps modulo 2^32
module riscv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned HANG_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load,
  input  logic        pc_reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] instr_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HW   = 8;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc_d, instr_d, count_d;
  logic [HW-1:0]   hang, hang_d;
  logic            req_d, valid_d, fault_d;

  // Address and opcode are straight views of registered state.
  assign imem_addr = pc;
  assign opcode    = instr[6:0];

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
      hang        <= '0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      fault       <= fault_d;
      instr_count <= count_d;
      hang        <= hang_d;
      imem_req    <= req_d;
    end
  end

  // Next-state and next-output logic; imem_req is registered, so it is
  // asserted exactly when the next state is REQ.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr;
    valid_d = instr_valid;
    fault_d = fault;
    count_d = instr_count;
    hang_d  = hang;
    req_d   = 1'b0;

    case (state)
      BOOT: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          count_d = instr_count + XLEN'(1);
          hang_d  = '0;
          state_d = ISSUE;
        end else begin
          req_d = 1'b1;
        end
      end
      ISSUE: begin
        if (pc_load) begin
          valid_d = 1'b0;
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = branch_taken ? branch_target : pc + XLEN'(4);
            state_d = REQ;
            req_d   = 1'b1;
          end
        end else begin
          hang_d = hang + HW'(1);
          // Fault on the cycle the counter reaches HANG_LIMIT.
          if (hang == HW'(HANG_LIMIT - 1)) begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Restart overrides everything, including a same-cycle memory response.
    if (pc_reset && (state != BOOT)) begin
      state_d = REQ;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
      fault_d = 1'b0;
      hang_d  = '0;
      count_d = instr_count;
      instr_d = instr;
      req_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: boot, fetch, sequential and branch pc
// updates, misaligned branch fault, hang fault, restart during a request,
// pc and counter wrap, and asynchronous reset mid-request.
module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_load, pc_reset, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc, instr;
  logic [6:0]  opcode;
  logic        instr_valid, fault;
  logic [31:0] instr_count;

  int vectors    = 0;
  int miscompares = 0;

  riscv_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .pc_load       (pc_load),
    .pc_reset      (pc_reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .fault         (fault),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch: present a word with imem_ready for one cycle.
  task automatic fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_load = 1'b0; pc_reset = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_ready = 1'b0; imem_rdata = '0;
    tick(); tick();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_op",    32'(opcode), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", instr_count, 32'd0);

    // Boot, then memory answers two cycles after the request rises.
    reset = 1'b0;
    tick();
    check("boot_req", 32'(imem_req), 32'd1);
    tick();
    check("wait_req",  32'(imem_req), 32'd1);
    check("wait_addr", imem_addr, 32'd0);
    fetch(32'h0000_0033);
    check("f1_op",    32'(opcode), 32'h33);
    check("f1_valid", 32'(instr_valid), 32'd1);
    check("f1_count", instr_count, 32'd1);
    check("f1_req",   32'(imem_req), 32'd0);
    tick();
    check("issue_hold", instr, 32'h0000_0033);

    // Sequential advance.
    pc_load = 1'b1; tick(); pc_load = 1'b0;
    check("seq_pc",    pc, 32'd4);
    check("seq_req",   32'(imem_req), 32'd1);
    check("seq_valid", 32'(instr_valid), 32'd0);

    // Taken branch to an aligned target.
    fetch(32'h0000_0063);
    check("f2_count", instr_count, 32'd2);
    pc_load = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    pc_load = 1'b0; branch_taken = 1'b0;
    check("br_pc",   pc, 32'h100);
    check("br_addr", imem_addr, 32'h100);
    check("br_req",  32'(imem_req), 32'd1);

    // Misaligned target faults, pc unchanged.
    fetch(32'h0000_0063);
    pc_load = 1'b1; branch_taken = 1'b1; branch_target = 32'h102;
    tick();
    pc_load = 1'b0; branch_taken = 1'b0;
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_pc",    pc, 32'h100);
    check("mis_req",   32'(imem_req), 32'd0);
    check("mis_valid", 32'(instr_valid), 32'd0);
    // Inputs in FAULT are ignored.
    imem_ready = 1'b1; pc_load = 1'b1; tick(); tick();
    imem_ready = 1'b0; pc_load = 1'b0;
    check("flt_req",   32'(imem_req), 32'd0);
    check("flt_count", instr_count, 32'd3);
    check("flt_pc",    pc, 32'h100);

    // Restart clears the fault.
    pc_reset = 1'b1; tick(); pc_reset = 1'b0;
    check("rs1_fault", 32'(fault), 32'd0);
    check("rs1_pc",    pc, 32'd0);
    check("rs1_req",   32'(imem_req), 32'd1);

    // Unknown opcode never retires: fault exactly 15 cycles after valid rises.
    fetch(32'hFFFF_FFFF);
    check("hang_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 14; i++) tick();
    check("hang_early", 32'(fault), 32'd0);
    tick();
    check("hang_fault", 32'(fault), 32'd1);
    check("hang_valid0", 32'(instr_valid), 32'd0);
    pc_reset = 1'b1; tick(); pc_reset = 1'b0;
    check("rs2_fault", 32'(fault), 32'd0);
    check("rs2_pc",    pc, 32'd0);

    // Restart coinciding with imem_ready drops the response.
    fetch(32'h0000_0013);
    check("f5_count", instr_count, 32'd5);
    pc_load = 1'b1; tick(); pc_load = 1'b0;
    check("f5_pc", pc, 32'd4);
    pc_reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0093;
    tick();
    pc_reset = 1'b0; imem_ready = 1'b0;
    check("co_count", instr_count, 32'd5);
    check("co_valid", 32'(instr_valid), 32'd0);
    check("co_addr",  imem_addr, 32'd0);
    check("co_req",   32'(imem_req), 32'd1);

    // pc wraps from 0xFFFF_FFFC; count wraps from 0xFFFF_FFFF.
    fetch(32'h0000_0063);
    pc_load = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0; branch_taken = 1'b0;
    check("hi_pc", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0013);
    force dut.instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count;
    pc_load = 1'b1; tick(); pc_load = 1'b0;
    check("wrap_pc",   pc, 32'd0);
    check("wrap_hold", instr_count, 32'hFFFF_FFFF);
    fetch(32'h0000_0013);
    check("wrap_count", instr_count, 32'd0);

    // Asynchronous reset between edges while requesting.
    pc_load = 1'b1; tick(); pc_load = 1'b0;
    check("pre_req", 32'(imem_req), 32'd1);
    check("pre_pc",  pc, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("ar_req",   32'(imem_req), 32'd0);
    check("ar_pc",    pc, 32'd0);
    check("ar_count", instr_count, 32'd0);
    tick();
    reset = 1'b0;
    check("ar_boot_req", 32'(imem_req), 32'd0);
    tick();
    check("ar_req_up", 32'(imem_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
